rr_bus_requester_4: RTL and testbench
=====================================

Name: rr_bus_requester_4

Overview:
- Requester-side front end for the 4-channel round-robin arbiter.
- Accepts data words from 4 independent sources (A..D = ch0..ch3) over valid/ready and buffers each in its own FIFO.
- Drives the arbiter's req[3:0] and consumes its registered one-hot grant[3:0].
- Places the granted channel's head word onto a shared, registered output bus tagged with the source index.

Parameters:
- DATA_W, 32, width of one data word.
- DEPTH, 4, entries per channel FIFO; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- src_data  in  4*DATA_W  channel i word at [i*DATA_W +: DATA_W].
- src_valid  in  4  per-channel word valid.
- src_ready  out  4  per-channel FIFO not full.
- req  out  4  request to arbiter, combinational.
- grant  in  4  one-hot grant from arbiter (registered at arbiter side).
- bus_data  out  DATA_W  registered shared bus data.
- bus_valid  out  1  registered; bus_data valid this cycle.
- bus_src  out  2  registered index of channel owning bus_data.
- grant_err  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: all FIFOs empty, src_ready=4'b1111, req=0, bus_data=0, bus_valid=0, bus_src=0, grant_err=0. Asserting rst mid-operation discards all buffered words immediately.
- Push: channel i pushes when src_valid[i] && src_ready[i]. src_ready[i] = (cnt[i] != DEPTH). A word pushed in cycle t is visible at the FIFO head in t+1.
- Pop: channel i pops when grant[i] is high, grant is exactly one-hot, and cnt[i] != 0.
- Bus register on pop: next edge loads bus_data <= head[i], bus_src <= i, bus_valid <= 1. With no pop, bus_valid <= 0; bus_data and bus_src hold.
- Request rule: req[i] = (cnt[i] > (grant[i] ? 1 : 0)).
  - A channel holding its last word drops req in the same cycle that word is granted.
  - This prevents the arbiter's one-cycle grant latency from producing a grant on an empty channel.
- Simultaneous push and pop on a channel: cnt unchanged. Push into a full channel is allowed only if src_ready was high; ready is not combinationally relieved by a pop.
- Pointers: read/write pointers are log2(DEPTH) bits and wrap naturally. cnt ranges 0..DEPTH.
- Error, grant not one-hot (0 excluded): no pop, bus_valid <= 0, grant_err <= 1.
- Error, grant[i] with cnt[i]==0: no pop, bus_valid <= 0, grant_err <= 1.
- grant_err clears only on rst.
- grant=0: idle, not an error.
- Throughput: one word per cycle on the bus when grants arrive back-to-back.
- Ordering: per-channel order is preserved; no ordering is implied between channels.

Decomposition:
- Shared package: NUM_CH=4, CH_IDX_W=2, and a onehot-to-index function used for bus_src.
- Natural sub-module: rr_req_fifo. One instance per channel, generated ×4.
  - Parameters: DATA_W, DEPTH.
  - Ports: push, push_data, pop, head, cnt, full, empty.
- Top level contains the req logic, grant check, bus mux/register and error flag.

Test Plan:
- Reset: assert rst mid-stream with ch1 holding 3 words -> same cycle src_ready=4'b1111, req=0, bus_valid=0, grant_err=0; after release ch1 is empty.
- Single channel: push 0xA0,0xA1 on ch2; drive grant=4'b0100 for 2 cycles -> bus_valid=1 for 2 cycles, data 0xA0 then 0xA1, bus_src=2. req[2] falls in the cycle of the second grant.
- Full: push 4 words into ch0 with no grant -> src_ready[0]=0 after the 4th push, and a 5th valid word is not accepted. One grant -> src_ready[0]=1 the next cycle.
- Concurrent push/pop: ch3 cnt=2, push and grant in the same cycle -> cnt stays 2; bus gets the old head.
- Error: grant=4'b0011 -> no pop, grant_err=1 sticky. Separately, grant=4'b1000 with ch3 empty -> grant_err=1, bus_valid=0.
- Closed loop with the arbiter: all 4 channels holding 2 words each -> bus_src sequence 0,1,2,3,0,1,2,3. No grant_err; all 8 words delivered in per-channel order.

Source files
------------

// File: rtl/rr_bus_requester_4_pkg.sv
// Shared constants and helpers for the 4-channel round-robin requester.
package rr_bus_requester_4_pkg;
  localparam int NUM_CH   = 4;
  localparam int CH_IDX_W = 2;

  typedef logic [NUM_CH-1:0] ch_vec_t;

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic logic [CH_IDX_W-1:0] onehot_to_idx(input ch_vec_t oh);
    logic [CH_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (oh[i]) idx = idx | CH_IDX_W'(i);
    return idx;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input ch_vec_t v);
    return (v != '0) && ((v & (v - ch_vec_t'(1))) == '0);
  endfunction
endpackage

// File: rtl/rr_bus_requester_4_if.sv
// Source handshake, arbiter req/grant and shared output bus of the requester.
interface rr_bus_requester_4_if
  import rr_bus_requester_4_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic [NUM_CH*DATA_W-1:0] src_data;
  ch_vec_t                  src_valid;
  ch_vec_t                  src_ready;
  ch_vec_t                  req;
  ch_vec_t                  grant;
  logic [DATA_W-1:0]        bus_data;
  logic                     bus_valid;
  logic [CH_IDX_W-1:0]      bus_src;
  logic                     grant_err;

  // Sources plus arbiter side (drives words and grants, observes the bus).
  modport master (
    output src_data, src_valid, grant,
    input  src_ready, req, bus_data, bus_valid, bus_src, grant_err
  );

  // The requester itself.
  modport slave (
    input  src_data, src_valid, grant,
    output src_ready, req, bus_data, bus_valid, bus_src, grant_err
  );
endinterface

// File: rtl/rr_bus_requester_4_fifo.sv
// Per-channel word FIFO; head is the oldest word, visible the cycle after push.
module rr_req_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  cnt,
  output logic              full,
  output logic              empty
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]             wptr, rptr;
  logic                         do_push, do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Storage needs no reset; only pointers and count define what is valid.
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= push_data;

  // Pointers wrap naturally; simultaneous push and pop leaves cnt unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/rr_bus_requester_4.sv
// Requester front end: per-channel FIFOs, arbiter requests, grant check and
// registered shared output bus with a sticky grant error flag.
module rr_bus_requester_4
  import rr_bus_requester_4_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic                  clk,
  input logic                  rst,
  rr_bus_requester_4_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0][DATA_W-1:0] head;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
  ch_vec_t                       full, empty, pop_vec;
  logic                          grant_ok, grant_bad, pop_any;
  logic [CH_IDX_W-1:0]           pop_idx;
  logic [DATA_W-1:0]             bus_data_q;
  logic                          bus_valid_q, grant_err_q;
  logic [CH_IDX_W-1:0]           bus_src_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rr_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.src_valid[i]),
      .push_data (bus.src_data[i*DATA_W +: DATA_W]),
      .pop       (pop_vec[i]),
      .head      (head[i]),
      .cnt       (cnt[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
    assign bus.src_ready[i] = !full[i];
    // A channel whose last word is being granted drops req right away so the
    // arbiter's registered grant never lands on an empty FIFO.
    assign bus.req[i] = cnt[i] > (bus.grant[i] ? CNT_W'(1) : CNT_W'(0));
  end

  assign grant_ok  = is_onehot(bus.grant);
  assign pop_vec   = grant_ok ? (bus.grant & ~empty) : '0;
  assign grant_bad = (bus.grant != '0) && (!grant_ok || ((bus.grant & empty) != '0));
  assign pop_any   = (pop_vec != '0);
  assign pop_idx   = onehot_to_idx(pop_vec);

  // Bus register: load popped head; otherwise drop valid and hold data/src.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_data_q  <= '0;
      bus_src_q   <= '0;
      bus_valid_q <= 1'b0;
    end else if (pop_any) begin
      bus_data_q  <= head[pop_idx];
      bus_src_q   <= pop_idx;
      bus_valid_q <= 1'b1;
    end else begin
      bus_valid_q <= 1'b0;
    end
  end

  // Sticky flag for malformed grants or grants on empty channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            grant_err_q <= 1'b0;
    else if (grant_bad) grant_err_q <= 1'b1;
  end

  assign bus.bus_data  = bus_data_q;
  assign bus.bus_src   = bus_src_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.grant_err = grant_err_q;
endmodule

// File: tb/tb_rr_bus_requester_4.sv
// Randomized and directed bench for rr_bus_requester_4 with a queue-based model.
module tb_rr_bus_requester_4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_bus_requester_4_if #(.DATA_W(32)) bif();
  rr_bus_requester_4 #(.DATA_W(32), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bif));

  // Behavioural model: one word queue per channel plus the bus register image.
  logic [31:0] q[4][$];
  logic [31:0] m_data;
  logic        m_valid, m_err;
  logic [1:0]  m_src;
  int          total = 0, bad = 0;
  int          last = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] m_req();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = q[i].size() > (bif.grant[i] ? 1 : 0);
    return r;
  endfunction

  function automatic logic [3:0] m_rdy();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = q[i].size() != DEPTH;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) q[i].delete();
    m_data = '0; m_valid = 1'b0; m_src = '0; m_err = 1'b0;
  endtask

  // One clock of the specified behaviour, evaluated on the pre-edge state.
  task automatic model_update();
    int pc;
    bit e;
    logic [3:0] rdy;
    if (rst) begin model_clear(); return; end
    pc = -1; e = 0;
    if (bif.grant != 4'b0) begin
      if ($countones(bif.grant) != 1) e = 1;
      else for (int i = 0; i < 4; i++)
        if (bif.grant[i]) begin
          if (q[i].size() == 0) e = 1;
          else pc = i;
        end
    end
    rdy = m_rdy();
    if (pc >= 0) begin
      m_data = q[pc].pop_front(); m_src = pc[1:0]; m_valid = 1'b1;
    end else m_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      if (bif.src_valid[i] && rdy[i]) q[i].push_back(bif.src_data[i*32 +: 32]);
    if (e) m_err = 1'b1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  task automatic chk();
    @(negedge clk);
    check("src_ready", 32'(bif.src_ready), 32'(m_rdy()));
    check("req",       32'(bif.req),       32'(m_req()));
    check("bus_valid", 32'(bif.bus_valid), 32'(m_valid));
    check("bus_data",  bif.bus_data,       m_data);
    check("bus_src",   32'(bif.bus_src),   32'(m_src));
    check("grant_err", 32'(bif.grant_err), 32'(m_err));
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    chk(); adv();
  endtask

  function automatic logic [3:0] rr_pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (r[c]) begin last = c; return 4'(1 << c); end
    end
    return 4'b0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; model_clear();
    bif.src_valid = '0; bif.grant = '0; bif.src_data = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic put(input int ch, input logic [31:0] d);
    bif.src_data[ch*32 +: 32] = d;
  endtask

  logic [1:0] seq[$];

  initial begin
    model_clear();
    bif.src_valid = '0; bif.grant = '0; bif.src_data = '0;
    #1;
    do_reset();

    // Reset mid-stream with three words buffered on ch1.
    bif.src_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin put(1, 32'h100 + k); step(); end
    bif.src_valid = '0;
    rst = 1'b1; model_clear();
    chk();
    check("rst_ready", 32'(bif.src_ready), 32'hF);
    check("rst_req",   32'(bif.req),       32'h0);
    check("rst_valid", 32'(bif.bus_valid), 32'h0);
    check("rst_err",   32'(bif.grant_err), 32'h0);
    adv(); rst = 1'b0;
    bif.grant = 4'b0010; step(); bif.grant = '0;
    chk();
    check("rst_ch1_empty", 32'(bif.grant_err), 32'h1);
    adv();
    do_reset();

    // Single channel: two words on ch2 drained by two grants.
    bif.src_valid = 4'b0100;
    put(2, 32'hA0); step();
    put(2, 32'hA1); step();
    bif.src_valid = '0; bif.grant = 4'b0100;
    chk(); check("sc_req_first", 32'(bif.req[2]), 32'h1); adv();
    chk();
    check("sc_req_drop", 32'(bif.req[2]),  32'h0);
    check("sc_data0",    bif.bus_data,     32'hA0);
    check("sc_src0",     32'(bif.bus_src), 32'h2);
    adv(); bif.grant = '0;
    chk();
    check("sc_data1",  bif.bus_data,       32'hA1);
    check("sc_valid1", 32'(bif.bus_valid), 32'h1);
    adv();
    do_reset();

    // Full: four pushes fill ch0, a fifth is refused, one pop frees a slot.
    bif.src_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin put(0, 32'hB0 + k); step(); end
    put(0, 32'hB4);
    chk(); check("full_ready", 32'(bif.src_ready[0]), 32'h0); adv();
    bif.src_valid = '0; bif.grant = 4'b0001;
    step(); bif.grant = '0;
    chk();
    check("full_relief", 32'(bif.src_ready[0]), 32'h1);
    check("full_head",   bif.bus_data,          32'hB0);
    adv();
    do_reset();

    // Concurrent push and pop on ch3.
    bif.src_valid = 4'b1000;
    put(3, 32'h30); step();
    put(3, 32'h31); step();
    put(3, 32'h32); bif.grant = 4'b1000; step();
    bif.src_valid = '0; bif.grant = '0;
    chk(); check("cc_old_head", bif.bus_data, 32'h30); adv();
    bif.grant = 4'b1000;
    step(); chk(); check("cc_second", bif.bus_data, 32'h31); adv();
    bif.grant = '0;
    chk(); check("cc_third", bif.bus_data, 32'h32); adv();
    do_reset();

    // Errors: two-hot grant, then grant on an empty channel.
    bif.src_valid = 4'b0011; put(0, 32'hE0); put(1, 32'hE1); step();
    bif.src_valid = '0; bif.grant = 4'b0011; step(); bif.grant = '0;
    chk();
    check("err_twohot", 32'(bif.grant_err), 32'h1);
    check("err_nopop",  32'(bif.bus_valid), 32'h0);
    adv(); step();
    chk(); check("err_sticky", 32'(bif.grant_err), 32'h1); adv();
    do_reset();
    bif.grant = 4'b1000; step(); bif.grant = '0;
    chk();
    check("err_empty",       32'(bif.grant_err), 32'h1);
    check("err_empty_valid", 32'(bif.bus_valid), 32'h0);
    adv();
    do_reset();

    // Closed loop with a round-robin arbiter model: two words per channel.
    bif.src_valid = 4'hF;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) put(c, 32'hC0 + 32'(c*2 + k));
      step();
    end
    bif.src_valid = '0; last = 3;
    for (int n = 0; n < 40 && seq.size() < 8; n++) begin
      logic [3:0] r;
      chk();
      if (bif.bus_valid) seq.push_back(bif.bus_src);
      r = m_req();
      adv();
      bif.grant = rr_pick(r);
    end
    check("cl_count", 32'(seq.size()), 32'd8);
    for (int k = 0; k < 8 && k < seq.size(); k++)
      check("cl_src", 32'(seq[k]), 32'(k % 4));
    check("cl_noerr", 32'(bif.grant_err), 32'h0);
    bif.grant = '0;
    do_reset();

    // Random traffic with a well-behaved arbiter.
    last = 3;
    for (int n = 0; n < 300; n++) begin
      logic [3:0] r;
      bif.src_valid = 4'($urandom);
      for (int c = 0; c < 4; c++) put(c, $urandom);
      r = m_req();
      step();
      bif.grant = rr_pick(r);
    end
    chk(); check("rand_noerr", 32'(bif.grant_err), 32'h0); adv();

    // Random traffic with occasional malformed grants.
    for (int n = 0; n < 150; n++) begin
      logic [3:0] r;
      bif.src_valid = 4'($urandom);
      for (int c = 0; c < 4; c++) put(c, $urandom);
      r = m_req();
      step();
      bif.grant = ($urandom_range(0, 4) == 0) ? 4'($urandom) : rr_pick(r);
    end
    bif.grant = '0; bif.src_valid = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
